// File: rtl/fp_add_sequencer.sv
// Operand-side front end for a single-precision floating-point adder.
// Queues operand pairs in a small FIFO, issues one pair at a time with a
// one-cycle load pulse, follows the adder's busy handshake and parks the
// result in a one-entry valid/ready output register.
module fp_add_sequencer #(
   parameter int DEPTH         = 4,
   parameter int START_TIMEOUT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   // operand producer side
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_a,
   input  logic [31:0]              in_b,
   // adder side
   output logic [31:0]              add_a,
   output logic [31:0]              add_b,
   output logic                     add_load,
   input  logic                     add_busy,
   input  logic                     add_status,
   input  logic [31:0]              add_sum,
   // result consumer side
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_sum,
   output logic                     out_status,
   // status
   output logic [$clog2(DEPTH):0]   count,
   output logic                     seq_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   // Timeout counter only has to hold 0 .. START_TIMEOUT-1.
   localparam int TW = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   // FIFO storage: {a, b} per entry. Contents need no reset; occupancy
   // is what defines which entries are live.
   logic [63:0]    r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;

   state_t         r_state;
   logic [TW-1:0]  r_tmo;
   logic [31:0]    r_add_a;
   logic [31:0]    r_add_b;
   logic           r_add_load;
   logic           r_out_valid;
   logic [31:0]    r_out_sum;
   logic           r_out_status;
   logic           r_seq_err;

   logic           w_in_ready;
   logic           w_push;
   logic           w_start;
   logic           w_timeout;
   logic           w_done;
   logic           w_pop;
   logic [63:0]    w_head;

   // The in-flight pair stays at the FIFO head until its result is
   // captured, so occupancy counts it and the head is only popped then.
   assign w_in_ready = (r_count < FULL_CNT);
   assign w_push     = in_valid && w_in_ready;
   assign w_head     = r_mem[r_rd_ptr];
   assign w_start    = (r_state == S_IDLE) && (r_count != '0) && !r_out_valid;
   assign w_timeout  = (r_state == S_WAIT_BUSY) && !add_busy && (r_tmo == TMO_LAST);
   assign w_done     = (r_state == S_WAIT_DONE) && !add_busy;
   assign w_pop      = w_timeout || w_done;

   // Write accepted operand pairs into the FIFO storage.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_a, in_b};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Issue/handshake FSM with registered adder and result outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_tmo        <= '0;
         r_add_a      <= '0;
         r_add_b      <= '0;
         r_add_load   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_sum    <= '0;
         r_out_status <= 1'b0;
         r_seq_err    <= 1'b0;
      end else begin
         r_add_load <= 1'b0;

         // Consumer drains the result register. A capture can never
         // coincide with this because issue requires an empty register.
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_add_a    <= w_head[63:32];
                  r_add_b    <= w_head[31:0];
                  r_add_load <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               r_tmo   <= '0;
               r_state <= S_WAIT_BUSY;
            end

            S_WAIT_BUSY: begin
               if (add_busy) begin
                  r_state <= S_WAIT_DONE;
               end else if (w_timeout) begin
                  // Adder never started: emit whatever sum it shows,
                  // flagged as an error, so the queue keeps moving.
                  r_seq_err    <= 1'b1;
                  r_out_sum    <= add_sum;
                  r_out_status <= 1'b1;
                  r_out_valid  <= 1'b1;
                  r_state      <= S_IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end

            S_WAIT_DONE: begin
               if (!add_busy) begin
                  r_out_sum    <= add_sum;
                  r_out_status <= add_status;
                  r_out_valid  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = w_in_ready;
   assign add_a      = r_add_a;
   assign add_b      = r_add_b;
   assign add_load   = r_add_load;
   assign out_valid  = r_out_valid;
   assign out_sum    = r_out_sum;
   assign out_status = r_out_status;
   assign count      = r_count;
   assign seq_err    = r_seq_err;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: stub adder, directed vectors and corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_fp_add_sequencer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_load;
   logic        add_busy = 1'b0;
   logic        add_status = 1'b0;
   logic [31:0] add_sum = 32'h0;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_status;
   logic [2:0]  count;
   logic        seq_err;

   fp_add_sequencer #(.DEPTH(DEPTH), .START_TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_load   (add_load),
      .add_busy   (add_busy),
      .add_status (add_status),
      .add_sum    (add_sum),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_status (out_status),
      .count      (count),
      .seq_err    (seq_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Stub adder result rule: the documented example pair gives its real
   // single-precision sum; any other pair gives the 32-bit pattern sum.
   function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h4048f5c3 && b == 32'h41200000) return 32'h41523d71;
      return a + b;
   endfunction

   function automatic logic ref_status(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h4048f5c3 && b == 32'h41200000) return 1'b0;
      return a[0] ^ b[0];
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // ---------------- stub adder ----------------
   logic        stub_never = 1'b0;
   logic        stub_rand  = 1'b0;
   int          s_phase = 0;
   int          s_dly   = 0;
   int          s_hold  = 0;
   logic [31:0] s_a, s_b;

   always @(negedge clk) begin
      if (reset) begin
         add_busy   = 1'b0;
         add_status = 1'b0;
         add_sum    = 32'h0;
         s_phase    = 0;
      end else if (add_load) begin
         s_a = add_a;
         s_b = add_b;
         if (stub_never) begin
            add_sum    = ref_sum(s_a, s_b);
            add_status = 1'b0;
            s_phase    = 0;
         end else begin
            s_dly   = stub_rand ? int'($urandom_range(1, 3)) : 1;
            s_phase = 1;
         end
      end else if (s_phase == 1) begin
         if (s_dly <= 1) begin
            add_busy = 1'b1;
            s_hold   = stub_rand ? int'($urandom_range(1, 4)) : 5;
            s_phase  = 2;
         end else begin
            s_dly--;
         end
      end else if (s_phase == 2) begin
         if (s_hold <= 1) begin
            add_busy   = 1'b0;
            add_sum    = ref_sum(s_a, s_b);
            add_status = ref_status(s_a, s_b);
            s_phase    = 0;
         end else begin
            s_hold--;
         end
      end
   end

   // ---------------- monitor / reference model ----------------
   int          n_loads = 0;
   int          n_res   = 0;
   logic [32:0] got_q[$];
   logic [63:0] mdl_q[$];
   int          mdl_cnt = 0;
   bit          pend_push = 1'b0;
   logic [63:0] pend_pair;
   bit          prev_ov = 1'b0;
   bit          chk_en = 1'b0;
   logic [63:0] mon_p;

   always @(negedge clk) begin
      if (reset) begin
         n_loads = 0;
      end else begin
         if (add_load) n_loads++;
         if (out_valid && out_ready) got_q.push_back({out_status, out_sum});
      end
      if (!chk_en || reset) begin
         mdl_cnt   = 0;
         pend_push = 1'b0;
         n_res     = 0;
         prev_ov   = out_valid;
      end else begin
         if (pend_push) begin
            mdl_q.push_back(pend_pair);
            mdl_cnt++;
         end
         if (out_valid && !prev_ov) mdl_cnt--;
         chk32("rnd_count", 32'(count), 32'(mdl_cnt));
         chk1("rnd_in_ready", in_ready, mdl_cnt < DEPTH);
         if (out_valid && out_ready) begin
            n_res++;
            if (mdl_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL rnd_result: got unexpected result 0x%08h, expected none", out_sum);
            end else begin
               mon_p = mdl_q.pop_front();
               chk32("rnd_sum", out_sum, ref_sum(mon_p[63:32], mon_p[31:0]));
               chk1("rnd_status", out_status, ref_status(mon_p[63:32], mon_p[31:0]));
            end
         end
         pend_push = in_valid && (mdl_cnt < DEPTH);
         pend_pair = {in_a, in_b};
         prev_ov   = out_valid;
      end
   end

   // ---------------- helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_ov(input string name, input int max);
      int i;
      i = 0;
      while (!out_valid && i < max) begin
         @(posedge clk);
         #1;
         i++;
      end
      chk1(name, out_valid, 1'b1);
   endtask

   task automatic drain_one();
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
   endtask

   task automatic wait_got(input int n, input int max);
      int i;
      i = 0;
      while (got_q.size() < n && i < max) begin
         step(1);
         i++;
      end
      chk32("got_count", 32'(got_q.size()), 32'(n));
   endtask

   task automatic chk_reset_values(input string tag);
      chk1({tag, "_add_load"}, add_load, 1'b0);
      chk32({tag, "_add_a"}, add_a, 32'h0);
      chk32({tag, "_add_b"}, add_b, 32'h0);
      chk1({tag, "_out_valid"}, out_valid, 1'b0);
      chk32({tag, "_out_sum"}, out_sum, 32'h0);
      chk1({tag, "_out_status"}, out_status, 1'b0);
      chk32({tag, "_count"}, 32'(count), 32'd0);
      chk1({tag, "_seq_err"}, seq_err, 1'b0);
      chk1({tag, "_in_ready"}, in_ready, 1'b1);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sum;
      logic        st;
   } vec_t;

   vec_t vt[6];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          l0;
      int          bad;
      logic [31:0] s;

      vt[0] = '{32'h4048f5c3, 32'h41200000, 32'h41523d71, 1'b0};
      vt[1] = '{32'h40a00000, 32'hc047ae14, 32'h00e7ae14, 1'b0};
      vt[2] = '{32'h00000001, 32'h00000002, 32'h00000003, 1'b1};
      vt[3] = '{32'hffffffff, 32'h00000001, 32'h00000000, 1'b0};
      vt[4] = '{32'h7f800000, 32'h80000000, 32'hff800000, 1'b0};
      vt[5] = '{32'h12345678, 32'h11111111, 32'h23456789, 1'b1};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_a      = 32'h0;
      in_b      = 32'h0;
      out_ready = 1'b0;
      step(2);
      reset = 1'b0;
      step(1);
      chk_reset_values("rst");

      // Push-to-load timing with the documented example pair.
      push(vt[0].a, vt[0].b);
      chk32("e0_count", 32'(count), 32'd1);
      chk1("e0_load", add_load, 1'b0);
      step(1);
      chk1("e1_load", add_load, 1'b1);
      chk32("e1_add_a", add_a, vt[0].a);
      chk32("e1_add_b", add_b, vt[0].b);
      step(1);
      chk1("e2_load", add_load, 1'b0);
      wait_ov("single_ov", 40);
      chk32("single_sum", out_sum, 32'h41523d71);
      chk1("single_status", out_status, 1'b0);
      chk32("single_count", 32'(count), 32'd0);
      chk32("single_loads", 32'(n_loads), 32'd1);
      drain_one();
      chk1("single_drained", out_valid, 1'b0);

      // Table of single operations.
      for (int i = 0; i < 6; i++) begin
         l0 = n_loads;
         push(vt[i].a, vt[i].b);
         wait_ov("vec_ov", 40);
         chk32("vec_sum", out_sum, vt[i].sum);
         chk1("vec_status", out_status, vt[i].st);
         chk32("vec_count", 32'(count), 32'd0);
         chk32("vec_loads", 32'(n_loads - l0), 32'd1);
         drain_one();
         chk1("vec_drained", out_valid, 1'b0);
      end

      // FIFO fill: four pairs fill it, the fifth is dropped.
      got_q.delete();
      l0 = n_loads;
      for (int i = 0; i < 4; i++) push(vt[i].a, vt[i].b);
      chk32("fill_count", 32'(count), 32'd4);
      chk1("fill_in_ready", in_ready, 1'b0);
      push(vt[4].a, vt[4].b);
      chk32("fill_count_after5", 32'(count), 32'd4);
      out_ready = 1'b1;
      wait_got(4, 200);
      step(20);
      out_ready = 1'b0;
      chk32("fill_results", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         chk32("fill_sum", got_q[i][31:0], vt[i].sum);
         chk1("fill_status", got_q[i][32], vt[i].st);
      end
      chk32("fill_loads", 32'(n_loads - l0), 32'd4);
      chk32("fill_count_end", 32'(count), 32'd0);

      // Backpressure: no second issue while the result is unread.
      l0 = n_loads;
      push(vt[4].a, vt[4].b);
      push(vt[5].a, vt[5].b);
      wait_ov("bp_ov1", 40);
      s = out_sum;
      chk32("bp_sum1", s, vt[4].sum);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (out_sum !== s || n_loads != l0 + 1 || !out_valid) bad++;
      end
      chk32("bp_stable_cycles_bad", 32'(bad), 32'd0);
      drain_one();
      wait_ov("bp_ov2", 40);
      chk32("bp_sum2", out_sum, vt[5].sum);
      chk32("bp_loads", 32'(n_loads - l0), 32'd2);
      drain_one();

      // Push on the capture edge at count 2.
      got_q.delete();
      push(vt[0].a, vt[0].b);
      push(vt[1].a, vt[1].b);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (add_busy) break;
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (!add_busy) break;
      end
      chk32("pc_count_before", 32'(count), 32'd2);
      in_valid = 1'b1;
      in_a     = vt[2].a;
      in_b     = vt[2].b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk32("pc_count_after", 32'(count), 32'd2);
      chk1("pc_out_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      wait_got(3, 200);
      step(2);
      out_ready = 1'b0;
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         chk32("pc_order_sum", got_q[i][31:0], vt[i].sum);
      end
      chk32("pc_count_end", 32'(count), 32'd0);

      // Start timeout: adder never raises busy.
      stub_never = 1'b1;
      push(vt[3].a, vt[3].b);
      chk32("to_count", 32'(count), 32'd1);
      step(1);
      chk1("to_load", add_load, 1'b1);
      step(4);
      chk1("to_err_early", seq_err, 1'b0);
      chk1("to_ov_early", out_valid, 1'b0);
      step(1);
      chk1("to_err", seq_err, 1'b1);
      chk1("to_ov", out_valid, 1'b1);
      chk1("to_status", out_status, 1'b1);
      chk32("to_sum", out_sum, vt[3].sum);
      chk32("to_count_pop", 32'(count), 32'd0);
      stub_never = 1'b0;
      drain_one();
      push(vt[1].a, vt[1].b);
      wait_ov("to_next_ov", 40);
      chk32("to_next_sum", out_sum, vt[1].sum);
      chk1("to_next_status", out_status, vt[1].st);
      chk1("to_err_sticky", seq_err, 1'b1);
      drain_one();

      // Reset in WAIT_DONE with three pairs queued behind the in-flight one.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(vt[i].a, vt[i].b);
      chk32("mr_count", 32'(count), 32'd4);
      out_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk_reset_values("mr");
      step(1);
      reset = 1'b0;
      got_q.delete();
      push(vt[2].a, vt[2].b);
      wait_ov("mr_ov", 40);
      chk32("mr_sum", out_sum, vt[2].sum);
      chk1("mr_status", out_status, vt[2].st);
      chk32("mr_count_end", 32'(count), 32'd0);
      chk32("mr_loads", 32'(n_loads), 32'd1);
      drain_one();

      // Randomized traffic against the queue model.
      step(2);
      mdl_q.delete();
      stub_rand = 1'b1;
      chk_en    = 1'b1;
      step(1);
      l0 = n_loads;
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_a      = $urandom;
         in_b      = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         step(1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step(150);
      chk32("rnd_model_empty", 32'(mdl_q.size()), 32'd0);
      chk32("rnd_count_end", 32'(count), 32'd0);
      chk32("rnd_loads", 32'(n_loads - l0), 32'(n_res));
      chk1("rnd_seq_err", seq_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
